// File: rtl/qu_mem_pkg.sv
// Shared types and lane helpers for the memory-port initiator.
// Size encoding, pipeline entry layout, store steering and load extension.
package qu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef struct packed {
        logic       valid;
        logic       we;
        size_e      size;
        logic       uns;
        logic [1:0] off;
        logic       err;
    } pipe_ent_t;

    function automatic logic misaligned(input size_e sz,
                                        input logic [1:0] off);
        logic m;
        m = 1'b0;
        unique case (1'b1)
            (sz == SZ_HALF): m = off[0];
            (sz == SZ_WORD): m = (off != 2'b00);
            (sz == SZ_ILL):  m = 1'b1;
            default:         m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_mask(input size_e sz,
                                             input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        unique case (1'b1)
            (sz == SZ_BYTE): m = 4'b0001 << off;
            (sz == SZ_HALF): m = 4'b0011 << off;
            (sz == SZ_WORD): m = 4'b1111;
            default:         m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_rep(input size_e sz,
                                              input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        unique case (1'b1)
            (sz == SZ_BYTE): r = {4{wd[7:0]}};
            (sz == SZ_HALF): r = {2{wd[15:0]}};
            default:         r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input size_e sz,
                                             input logic uns,
                                             input logic [1:0] off,
                                             input logic [31:0] dout);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = dout[{off, 3'b000} +: 8];
        h = off[1] ? dout[31:16] : dout[15:0];
        r = dout;
        unique case (1'b1)
            (sz == SZ_BYTE): r = {{24{~uns & b[7]}}, b};
            (sz == SZ_HALF): r = {{16{~uns & h[15]}}, h};
            default:         r = dout;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qu_sync_fifo.sv
// Small synchronous FIFO with async active-low reset.
// Head word is visible on dout while not empty.
module qu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign dout   = mem[rptr];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= inc(wptr);
            end
            if (do_pop)
                rptr <= inc(rptr);
            if (push && !do_pop)
                count <= count + 1'b1;
            else if (!push && do_pop)
                count <= count - 1'b1;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && full && !do_pop)
    );

endmodule

// File: rtl/mem_port_initiator.sv
// Load/store initiator for one byte-write read-first BRAM port.
// Issues in the accept cycle; in-order responses with credit backpressure.
module mem_port_initiator
    import qu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2,
    parameter int RSP_DEPTH  = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic                  ram_regce,
    output logic                  ram_rst,
    input  logic [31:0]           ram_dout,
    input  logic                  ram_valid,
    output logic                  proto_err
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int FW = 33 + TAG_WIDTH;

    size_e      sz;
    logic [1:0] off;
    logic       mis;
    logic       acc;

    assign sz  = size_e'(req_size);
    assign off = req_addr[1:0];
    assign mis = misaligned(sz, off);
    assign acc = req_valid && req_ready;

    assign ram_addr  = req_addr[ADDR_WIDTH-1:2];
    assign ram_din   = store_rep(sz, req_wdata);
    assign ram_en    = acc && !mis;
    assign ram_we    = (acc && !mis && req_we) ? lane_mask(sz, off) : 4'b0000;
    assign ram_regce = 1'b1;
    assign ram_rst   = !rst_n;

    pipe_ent_t            pipe [RD_LATENCY];
    logic [TAG_WIDTH-1:0] ptag [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
                ptag[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: acc, we: req_we, size: sz,
                         uns: req_unsigned, off: off, err: mis};
            ptag[0] <= req_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
                ptag[i] <= ptag[i-1];
            end
        end
    end

    // Entry leaving the last stage lines up with ram_dout for its load.
    pipe_ent_t   ex;
    logic        ld_ok;
    logic [31:0] ex_data;
    logic        fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [FW-1:0] fifo_dout;

    assign ex      = pipe[RD_LATENCY-1];
    assign ld_ok   = ex.valid && !ex.we && !ex.err;
    assign ex_data = ld_ok ? load_ext(ex.size, ex.uns, ex.off, ram_dout)
                           : 32'h0;

    qu_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ex.valid),
        .din   ({ex.err, ptag[RD_LATENCY-1], ex_data}),
        .pop   (rsp_valid && rsp_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    logic [CW-1:0] pipe_cnt;
    logic [CW-1:0] used;

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            pipe_cnt = pipe_cnt + CW'(pipe[i].valid);
    end

    assign used      = pipe_cnt + fifo_cnt;
    assign req_ready = rst_n && (used < CW'(RSP_DEPTH));

    assign rsp_valid = !fifo_empty;
    assign {rsp_err, rsp_tag, rsp_rdata} = fifo_empty ? '0 : fifo_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            proto_err <= 1'b0;
        else if (ld_ok && !ram_valid)
            proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench for mem_port_initiator with a read-first BRAM model.
// Latency-2 output-register RAM; valid flag can be forced low.
module tb_mem_port_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  rsp_tag;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_regce;
    logic        ram_rst;
    logic [31:0] ram_dout;
    logic        ram_valid = 1'b0;
    logic        proto_err;

    mem_port_initiator #(
        .ADDR_WIDTH (12),
        .RD_LATENCY (2),
        .RSP_DEPTH  (4),
        .TAG_WIDTH  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_tag      (rsp_tag),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_regce    (ram_regce),
        .ram_rst      (ram_rst),
        .ram_dout     (ram_dout),
        .ram_valid    (ram_valid),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first byte-write RAM, two-cycle read path.
    logic [31:0] mem [0:1023];
    logic [31:0] rd1;
    logic        v1 = 1'b0;
    logic        force_inv;

    always @(posedge clk) begin
        v1 <= ram_en && (ram_we == 4'b0000) && !force_inv;
        if (ram_en) begin
            rd1 <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b])
                    mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout  <= rd1;
        ram_valid <= v1;
    end

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic [3:0]  t;
        int          c;
    } rsp_t;

    rsp_t rq[$];

    always @(negedge clk)
        if (rst_n && rsp_valid && rsp_ready)
            rq.push_back('{d: rsp_rdata, e: rsp_err, t: rsp_tag, c: cyc});

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic       s_en;
    logic [3:0] s_we;
    logic [31:0] s_din;
    int         s_cyc;

    task automatic send(input logic we, input logic [11:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] wd, input logic [3:0] tg);
        bit done;
        done = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_size = sz;
        req_unsigned = u;
        req_wdata = wd;
        req_tag = tg;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                s_en = ram_en;
                s_we = ram_we;
                s_din = ram_din;
                s_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] d,
                              input logic e, input logic [3:0] t,
                              output int c);
        rsp_t r;
        c = 0;
        for (int i = 0; i < 40 && rq.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (rq.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        r = rq.pop_front();
        c = r.c;
        chk({tag, "_data"}, r.d, d);
        chk({tag, "_err"}, 32'(r.e), 32'(e));
        chk({tag, "_tag"}, 32'(r.t), 32'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    int c;
    int t0;
    int acc;
    logic e0, e1, e2;

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        force_inv = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 12'h010;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_wdata = 32'hDEADBEEF;
        req_tag = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_rst", 32'(ram_rst), 32'd1);
        chk("ram_regce", 32'(ram_regce), 32'd1);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: word store then word load, latency
        send(1'b1, 12'h010, 2'b10, 1'b0, 32'h80FF7F01, 4'd1);
        chk("t1_sw_en", 32'(s_en), 32'd1);
        chk("t1_sw_we", 32'(s_we), 32'hF);
        chk("t1_sw_din", s_din, 32'h80FF7F01);
        expect_rsp("t1_sw", 32'h0, 1'b0, 4'd1, c);
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd2);
        t0 = s_cyc;
        chk("t1_lw_we", 32'(s_we), 32'h0);
        expect_rsp("t1_lw", 32'h80FF7F01, 1'b0, 4'd2, c);
        chk("t1_latency", 32'(c - t0), 32'd3);

        // 2: sub-word loads with extension
        send(1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 4'd3);
        send(1'b0, 12'h013, 2'b00, 1'b1, 32'h0, 4'd4);
        send(1'b0, 12'h012, 2'b01, 1'b0, 32'h0, 4'd5);
        send(1'b0, 12'h012, 2'b01, 1'b1, 32'h0, 4'd6);
        expect_rsp("t2_lb", 32'hFFFFFF80, 1'b0, 4'd3, c);
        expect_rsp("t2_lbu", 32'h00000080, 1'b0, 4'd4, c);
        expect_rsp("t2_lh", 32'hFFFF80FF, 1'b0, 4'd5, c);
        expect_rsp("t2_lhu", 32'h000080FF, 1'b0, 4'd6, c);

        // 3: byte store, then load the next cycle
        send(1'b1, 12'h011, 2'b00, 1'b0, 32'h000000AB, 4'd7);
        chk("t3_sb_we", 32'(s_we), 32'h2);
        chk("t3_sb_din", s_din, 32'hABABABAB);
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd8);
        expect_rsp("t3_sb", 32'h0, 1'b0, 4'd7, c);
        expect_rsp("t3_lw", 32'h80FFAB01, 1'b0, 4'd8, c);

        // 4: good load, then two misaligned
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd9);
        e0 = s_en;
        send(1'b0, 12'h012, 2'b10, 1'b0, 32'h0, 4'd10);
        e1 = s_en;
        send(1'b0, 12'h011, 2'b01, 1'b0, 32'h0, 4'd11);
        e2 = s_en;
        chk("t4_en0", 32'(e0), 32'd1);
        chk("t4_en1", 32'(e1), 32'd0);
        chk("t4_en2", 32'(e2), 32'd0);
        expect_rsp("t4_r0", 32'h80FFAB01, 1'b0, 4'd9, c);
        expect_rsp("t4_r1", 32'h0, 1'b1, 4'd10, c);
        expect_rsp("t4_r2", 32'h0, 1'b1, 4'd11, c);

        // 5: credit limit with the consumer stalled
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 40 && acc < 6; k++) begin
            if (k == 8) rsp_ready = 1'b1;
            req_valid = 1'b1;
            req_we = 1'b0;
            req_addr = 12'h010;
            req_size = 2'b10;
            req_unsigned = 1'b0;
            req_tag = 4'(acc);
            @(negedge clk);
            if (k == 4 || k == 7) begin
                chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("t5_hold_tag", 32'(rsp_tag), 32'd0);
                chk("t5_hold_data", rsp_rdata, 32'h80FFAB01);
            end
            if (k == 7) begin
                chk("t5_acc_cap", 32'(acc), 32'd4);
                chk("t5_ready_low", 32'(req_ready), 32'd0);
            end
            if (req_ready) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("t5_acc_all", 32'(acc), 32'd6);
        for (int k = 0; k < 6; k++)
            expect_rsp("t5_r", 32'h80FFAB01, 1'b0, 4'(k), c);

        // 6: reset with loads in flight, then missing valid flag
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd12);
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd13);
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd14);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_tag", 32'(rsp_tag), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_stale", 32'(rq.size()), 32'd0);
        chk("t6_proto_clear", 32'(proto_err), 32'd0);
        force_inv = 1'b1;
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd15);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_proto_set", 32'(proto_err), 32'd1);
        force_inv = 1'b0;
        expect_rsp("t6_pe", 32'h80FFAB01, 1'b0, 4'd15, c);
        send(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4'd1);
        expect_rsp("t6_after", 32'h80FFAB01, 1'b0, 4'd1, c);
        chk("t6_proto_sticky", 32'(proto_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
